// File: rtl/intmul_share_ctrl_pkg.sv
// Shared constants, helper function and tag type for the shared-multiplier controller.
package intmul_share_pkg;

  localparam int NREQ_DEF    = 2;
  localparam int LOGA_DEF    = 34;
  localparam int LOGB_DEF    = 43;
  localparam int MUL_LAT_DEF = 4;
  // Tag id is sized for the largest supported requester count (8).
  localparam int TAG_IDW     = 3;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < n) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  typedef struct packed {
    logic               v;
    logic [TAG_IDW-1:0] id;
  } tag_t;

endpackage

// File: rtl/intmul_share_ctrl_if.sv
// Requester handshake and response bus of the shared-multiplier controller.
interface intmul_share_ctrl_if
  import intmul_share_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int LOGA = LOGA_DEF,
  parameter int LOGB = LOGB_DEF,
  parameter int IDW  = 1
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*LOGA-1:0] req_A;
  logic [NREQ*LOGB-1:0] req_B;
  logic                 resp_valid;
  logic [IDW-1:0]       resp_id;
  logic [LOGA+LOGB-1:0] resp_C;

  modport master (
    output req_valid, req_A, req_B,
    input  req_ready, resp_valid, resp_id, resp_C
  );

  modport slave (
    input  req_valid, req_A, req_B,
    output req_ready, resp_valid, resp_id, resp_C
  );
endinterface

// File: rtl/intmul_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: first valid requester at or after ptr, wrapping modulo NREQ.
module rr_arbiter
  import intmul_share_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic            en,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id
);

  logic [IDW-1:0] idx_s;
  logic           found_s;

  // Priority search starting at the round-robin pointer.
  always_comb begin
    grant    = {NREQ{1'b0}};
    grant_id = {IDW{1'b0}};
    idx_s    = {IDW{1'b0}};
    found_s  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = IDW'((32'(ptr) + k) % NREQ);
      if (en && !found_s && req[idx_s]) begin
        grant[idx_s] = 1'b1;
        grant_id     = idx_s;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/intmul_share_ctrl.sv
// Shares one pipelined multiplier among NREQ requesters; a tag pipeline of
// MUL_LAT stages steers each product back to the requester that issued it.
module intmul_share_ctrl
  import intmul_share_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int LOGA    = LOGA_DEF,
  parameter int LOGB    = LOGB_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int IDW     = (clog2(NREQ) < 1) ? 1 : clog2(NREQ),
  localparam int CW     = clog2(MUL_LAT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  intmul_share_ctrl_if.slave   bus,
  output logic [LOGA-1:0]      mul_A,
  output logic [LOGB-1:0]      mul_B,
  input  logic [LOGA+LOGB-1:0] mul_C,
  output logic [CW-1:0]        inflight,
  output logic                 busy
);

  logic [NREQ-1:0] grant_s;
  logic [IDW-1:0]  grant_id_s;
  logic            en_s;
  logic            xfer_s;
  logic            resp_s;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  tag_t            tag_q [MUL_LAT];
  tag_t            tag_d [MUL_LAT];
  logic [CW-1:0]   inflight_q, inflight_d;
  logic            busy_q, busy_d;

  // Grants are suppressed while reset is held so nothing is accepted then.
  assign en_s = en & ~rst;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req      (bus.req_valid),
    .en       (en_s),
    .ptr      (rr_ptr_q),
    .grant    (grant_s),
    .grant_id (grant_id_s)
  );

  assign xfer_s         = |grant_s;
  assign resp_s         = tag_q[MUL_LAT-1].v;
  assign bus.req_ready  = grant_s;
  assign bus.resp_valid = tag_q[MUL_LAT-1].v;
  assign bus.resp_id    = tag_q[MUL_LAT-1].id[IDW-1:0];
  assign bus.resp_C     = mul_C;
  assign inflight       = inflight_q;
  assign busy           = busy_q;

  // Operand mux: only a transfer cycle drives non-zero operands.
  always_comb begin
    mul_A = {LOGA{1'b0}};
    mul_B = {LOGB{1'b0}};
    if (xfer_s) begin
      mul_A = bus.req_A[grant_id_s*LOGA +: LOGA];
      mul_B = bus.req_B[grant_id_s*LOGB +: LOGB];
    end else begin
      mul_A = {LOGA{1'b0}};
      mul_B = {LOGB{1'b0}};
    end
  end

  // Next state for pointer, tag shadow pipeline and in-flight counter.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer_s) begin
      if (grant_id_s == IDW'(NREQ - 1)) begin
        rr_ptr_d = {IDW{1'b0}};
      end else begin
        rr_ptr_d = grant_id_s + IDW'(1'b1);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end

    tag_d[0].v  = xfer_s;
    tag_d[0].id = {TAG_IDW{1'b0}};
    tag_d[0].id[IDW-1:0] = grant_id_s;
    for (int k = 1; k < MUL_LAT; k++) begin
      tag_d[k] = tag_q[k-1];
    end

    case ({xfer_s, resp_s})
      2'b10:   inflight_d = inflight_q + CW'(1'b1);
      2'b01:   inflight_d = inflight_q - CW'(1'b1);
      default: inflight_d = inflight_q;
    endcase
    busy_d = (inflight_d != {CW{1'b0}});
  end

  // State registers; reset drops every tag so stale products never respond.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= {IDW{1'b0}};
      inflight_q <= {CW{1'b0}};
      busy_q     <= 1'b0;
      for (int k = 0; k < MUL_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      inflight_q <= inflight_d;
      busy_q     <= busy_d;
      for (int k = 0; k < MUL_LAT; k++) begin
        tag_q[k] <= tag_d[k];
      end
    end
  end

endmodule

// File: tb/tb_intmul_share_ctrl.sv
// Scoreboard bench for intmul_share_ctrl with a behavioural pipelined multiplier.
module tb_intmul_share_ctrl;

  localparam int NREQ = 2;
  localparam int LOGA = 34;
  localparam int LOGB = 43;
  localparam int LAT  = 4;
  localparam int IDW  = 1;
  localparam int CW   = 3;

  typedef struct {
    int               due;
    int               id;
    logic [LOGA+LOGB-1:0] prod;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic [LOGA-1:0]      mul_A;
  logic [LOGB-1:0]      mul_B;
  logic [LOGA+LOGB-1:0] mul_C;
  logic [CW-1:0]        inflight;
  logic                 busy;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  int   out_m = 0;
  int   ptr_m = 0;
  logic [LOGA+LOGB-1:0] mpipe [LAT];

  intmul_share_ctrl_if #(.NREQ(NREQ), .LOGA(LOGA), .LOGB(LOGB), .IDW(IDW)) bus ();

  intmul_share_ctrl #(.NREQ(NREQ), .LOGA(LOGA), .LOGB(LOGB), .MUL_LAT(LAT), .IDW(IDW)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .bus      (bus),
    .mul_A    (mul_A),
    .mul_B    (mul_B),
    .mul_C    (mul_C),
    .inflight (inflight),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural multiplier: operands sampled on the edge, product LAT cycles later.
  always @(posedge clk) begin
    mpipe[0] <= (LOGA+LOGB)'(mul_A) * (LOGA+LOGB)'(mul_B);
    for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mul_C = mpipe[LAT-1];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic set_op(input int i, input logic [LOGA-1:0] a, input logic [LOGB-1:0] b);
    bus.req_A[i*LOGA +: LOGA] = a;
    bus.req_B[i*LOGB +: LOGB] = b;
    bus.req_valid[i] = 1'b1;
  endtask

  // Issue model: reference round-robin grant, operand mux and in-flight count.
  initial forever begin
    int g;
    logic [NREQ-1:0] exp_rdy;
    logic [LOGA-1:0] ea;
    logic [LOGB-1:0] eb;
    @(negedge clk);
    if (rst) begin
      chk("ready_in_reset", bus.req_ready, 0);
      sb.delete();
      out_m = 0;
      ptr_m = 0;
    end else begin
      chk("inflight", inflight, out_m);
      chk("busy", busy, (out_m != 0));
      g = en ? rr_pick(bus.req_valid, ptr_m) : -1;
      exp_rdy = '0;
      ea = '0;
      eb = '0;
      if (g >= 0) begin
        exp_rdy[g] = 1'b1;
        ea = bus.req_A[g*LOGA +: LOGA];
        eb = bus.req_B[g*LOGB +: LOGB];
      end
      chk("req_ready", bus.req_ready, exp_rdy);
      chk("mul_A", mul_A, ea);
      chk("mul_B", mul_B, eb);
      if (sb.size() > 0 && sb[0].due == cyc) out_m--;
      if (g >= 0) begin
        sb.push_back('{due: cyc + LAT, id: g,
                       prod: (LOGA+LOGB)'(ea) * (LOGA+LOGB)'(eb)});
        out_m++;
        ptr_m = (g + 1) % NREQ;
      end
    end
  end

  // Response monitor: pops the scoreboard whenever a response is due or shows up.
  initial forever begin
    exp_t e;
    @(negedge clk);
    #1;
    if (!rst) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        chk("resp_valid", bus.resp_valid, 1);
        chk("resp_id", bus.resp_id, e.id);
        chk("resp_C", bus.resp_C, e.prod);
      end else begin
        chk("resp_valid_idle", bus.resp_valid, 0);
      end
    end
  end

  initial begin
    int n;
    logic [NREQ-1:0] acc;
    logic [63:0] ra;
    logic [63:0] rb;
    logic [LOGA+LOGB-1:0] big_exp;

    rst = 1'b1;
    en  = 1'b0;
    bus.req_valid = '0;
    bus.req_A = '0;
    bus.req_B = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    en = 1'b1;
    chk("reset_inflight", inflight, 0);
    chk("reset_resp_valid", bus.resp_valid, 0);

    // Single maximal op: latency and exact product.
    big_exp = ((LOGA+LOGB)'(1) << 77) - ((LOGA+LOGB)'(1) << 43) - ((LOGA+LOGB)'(1) << 34) + (LOGA+LOGB)'(1);
    set_op(0, {LOGA{1'b1}}, {LOGB{1'b1}});
    @(posedge clk);
    #1 bus.req_valid = '0;
    n = 1;
    while (!bus.resp_valid && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    chk("t1_latency", n, LAT);
    chk("t1_id", bus.resp_id, 0);
    chk("t1_prod", bus.resp_C, big_exp);
    repeat (3) @(posedge clk);
    #1 chk("t1_busy_done", busy, 0);

    // Both requesters continuously valid from a fresh pointer.
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    set_op(0, 34'd3, 43'd5);
    set_op(1, 34'd7, 43'd11);
    repeat (4) @(posedge clk);
    #1 chk("t2_inflight_full", inflight, LAT);
    repeat (2) @(posedge clk);
    #1 bus.req_valid = '0;
    repeat (LAT + 2) @(posedge clk);

    // Only requester 1, pointer at 0: granted at once, back to back.
    #1 set_op(1, 34'd13, 43'd17);
    repeat (4) @(posedge clk);
    #1 bus.req_valid = '0;
    repeat (LAT + 2) @(posedge clk);

    // Two ops in flight, then en low with both valid: pipeline drains.
    #1 set_op(0, 34'd100, 43'd200);
    set_op(1, 34'd300, 43'd400);
    repeat (2) @(posedge clk);
    #1 en = 1'b0;
    repeat (8) @(posedge clk);
    #1 chk("t4_busy_drained", busy, 0);
    chk("t4_inflight_drained", inflight, 0);
    bus.req_valid = '0;
    en = 1'b1;

    // Reset with three ops in flight; then one clean op.
    set_op(0, 34'd21, 43'd22);
    set_op(1, 34'd23, 43'd24);
    repeat (3) @(posedge clk);
    #1 bus.req_valid = '0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (LAT + 2) @(posedge clk);
    #1 chk("t5_inflight_zero", inflight, 0);
    set_op(1, 34'd123456789, 43'd987654321);
    @(posedge clk);
    #1 bus.req_valid = '0;
    n = 1;
    while (!bus.resp_valid && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    chk("t5_latency", n, LAT);
    chk("t5_id", bus.resp_id, 1);
    chk("t5_prod", bus.resp_C, 77'd121932631112635269);
    repeat (3) @(posedge clk);

    // Random traffic with hold-until-accepted requesters.
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i] || acc[i]) begin
          if ($urandom_range(0, 2) != 0) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            set_op(i, ra[LOGA-1:0], rb[LOGB-1:0]);
          end else begin
            bus.req_valid[i] = 1'b0;
          end
        end
      end
      en = ($urandom_range(0, 9) != 0);
    end
    bus.req_valid = '0;
    en = 1'b1;
    repeat (LAT + 3) @(posedge clk);
    #1 chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/intmul_share_ctrl.md
Name: intmul_share_ctrl

Overview:
- Shares one fully pipelined integer multiplier (intmul_nonstd_34x43, initiation interval 1, fixed latency LAT) between NREQ requesters.
- Round-robin arbitration; at most one operand pair issued per cycle.
- A tag shadow pipeline of depth MUL_LAT routes each product back to its requester. Stale multiplier pipeline contents after reset never produce a response.
- Sits between modular-multiplier front ends and the shared multiplier instance.

Parameters:
- NREQ, 2, number of requesters (2..8).
- LOGA, 34, width of operand A.
- LOGB, 43, width of operand B.
- MUL_LAT, 4, multiplier latency in cycles from operand presentation to C. Must equal the instance's LAT.
- IDW, 1, requester-id width, equal to clog2(NREQ), minimum 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  issue enable; 0 blocks new grants while in-flight ops drain.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept (one-hot or zero).
- req_A  in  NREQ*LOGA  packed operand A, requester i at [i*LOGA +: LOGA].
- req_B  in  NREQ*LOGB  packed operand B, same packing.
- mul_A  out  LOGA  operand A to multiplier.
- mul_B  out  LOGB  operand B to multiplier.
- mul_C  in  LOGA+LOGB  product from multiplier.
- resp_valid  out  1  product on resp_C is valid this cycle.
- resp_id  out  IDW  requester index owning resp_C.
- resp_C  out  LOGA+LOGB  product, equal to mul_C.
- inflight  out  clog2(MUL_LAT+1)  ops currently in the multiplier.
- busy  out  1  inflight != 0.

Behaviour:
- Handshake: a transfer occurs on requester i when req_valid[i] & req_ready[i] at a rising edge. Requesters hold A, B and valid until accepted. Responses have no backpressure; consumers always accept.
- Grant (combinational): if en=1 and !rst, grant the first i with req_valid[i], searching from rr_ptr upward with wrap modulo NREQ. req_ready = one-hot grant, else 0.
  - req_ready never depends on anything but req_valid, en, rr_ptr, rst.
- rr_ptr: register, reset 0. On transfer by i, rr_ptr <= (i+1) mod NREQ; otherwise it holds.
- Operand mux: mul_A/mul_B = granted requester's operands on a transfer cycle, else all zeros.
  - This matches the cycle on which the multiplier samples operands; tb convention: inputs applied, C valid MUL_LAT cycles later.
- Tag pipeline: MUL_LAT stages of {v, id}. Stage 0 loads {transfer, granted id} each cycle; stage k loads stage k-1.
  - resp_valid/resp_id = last stage, so resp_valid asserts exactly MUL_LAT cycles after the transfer edge.
  - resp_C is combinationally equal to mul_C. It is don't-care when resp_valid=0, but the bench checks only when valid.
- inflight: +1 on transfer, -1 on response, unchanged when both or neither occur. Saturates at MUL_LAT by construction (≤ one issue per cycle).
- en deassert: blocks new transfers only. The pipeline drains; busy falls MUL_LAT cycles after the last issue.
- Reset (also mid-operation): rr_ptr=0, all tag stages v=0, inflight=0.
  - Outputs during/after reset: req_ready=0 while rst=1, resp_valid=0, resp_id=0, busy=0, mul_A=mul_B=0.
  - Products of ops issued before reset are silently discarded.
- Back-to-back: full throughput, one response per cycle when requesters are continuously valid.
- NREQ=1: rr_ptr stays 0; req_ready = req_valid & en.

Decomposition:
- Package intmul_share_pkg holds:
  - default LOGA/LOGB/MUL_LAT/NREQ constants;
  - a clog2 function;
  - the tag struct/typedef {v, id}.
- One sub-module, rr_arbiter (NREQ; inputs req, en, ptr; outputs grant one-hot, grant_id). The tag pipeline and counters stay in the top.

Test Plan:
- Reset then single op: req0 A=2^34-1, B=2^43-1 -> req_ready[0] same cycle. Then resp_valid=1, resp_id=0, resp_C=2^77-2^43-2^34+1 exactly MUL_LAT cycles later; inflight 1 during, busy falls after.
- Both requesters continuously valid (req0 A=3,B=5; req1 A=7,B=11) for 6 cycles -> grants alternate 0,1,0,1,0,1. Responses are 15,77 alternating, ids 0,1, on consecutive cycles; inflight reaches MUL_LAT.
- Only req1 valid, rr_ptr=0 -> req1 granted immediately; rr_ptr becomes 0 (wrap); no bubble cycles across 4 back-to-back ops.
- en=0 with both valid -> req_ready=0, mul_A=mul_B=0. Prior in-flight ops still complete; busy=0 after drain.
- rst asserted with 3 ops in flight -> no resp_valid for the following MUL_LAT cycles; inflight=0, rr_ptr=0. First post-reset op returns correct product and id.
- Random: 1000 cycles, random valids/operands, NREQ=2 -> every accepted op yields exactly one response with the correct id and A*B, in issue order.
